// File: rtl/transpose_rx_buffer.sv
// Receive-side NUM_PE x NUM_PE chunk buffer for the transpose path.
// Ports: clk/rst, ctrl (mode, sampled on the first row of a block),
//   in_valid/in_ready/in_elements (row input),
//   out_valid/out_ready/out_elements/out_last (vector output), busy (draining).
module transpose_rx_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ctrl,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [0:NUM_PE-1][DATA_WIDTH-1:0]      in_elements,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [0:NUM_PE-1][DATA_WIDTH-1:0]      out_elements,
  output logic                                   out_last,
  output logic                                   busy
);

  localparam int CW = $clog2(NUM_PE);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_PE - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            mode_q, mode_d;
  logic            in_fire;

  logic [DATA_WIDTH-1:0] mem_q [NUM_PE][NUM_PE];

  assign in_fire = in_valid && (state_q == FILL);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (row_q == '0) mode_d = ctrl;
          if (row_q == CNT_MAX) begin
            row_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (col_q == CNT_MAX) begin
            col_d   = '0;
            state_d = FILL;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == DRAIN);
    busy      = (state_q == DRAIN);
    out_last  = (col_q == CNT_MAX);
  end

  // Chunk storage: one row written per accepted beat
  for (genvar gr = 0; gr < NUM_PE; gr++) begin : g_row
    for (genvar gc = 0; gc < NUM_PE; gc++) begin : g_col
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gr][gc] <= '0;
        end else if (in_fire && row_q == CW'(gr)) begin
          mem_q[gr][gc] <= in_elements[gc];
        end
      end
    end
  end

  // Column read when transposing, row read when passing through
  for (genvar gj = 0; gj < NUM_PE; gj++) begin : g_out
    assign out_elements[gj] = mode_q ? mem_q[gj][col_q]
                                     : mem_q[col_q][gj];
  end

endmodule
